// File: rtl/fixed_matrix_dot_pkg.sv
// Shared types and helpers for the fixed-size matrix product scheduler.
// Holds the controller state encoding and a clog2 variant that never returns zero.
package fixed_matrix_dot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fixed_matrix_dot_scheduler.sv
// Sequences A/B memory reads into an external streaming MAC and writes each
// dot-product result to C memory; completion is tracked purely by results received.
module fixed_matrix_dot_scheduler
  import fixed_matrix_dot_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int ROWS  = 4,
  parameter int INNER = 10,
  parameter int COLS  = 4,
  localparam int AW = clog2_min1(ROWS * INNER),
  localparam int BW = clog2_min1(INNER * COLS),
  localparam int CW = clog2_min1(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   a_addr,
  input  logic [BITS-1:0] a_data,
  output logic [BW-1:0]   b_addr,
  input  logic [BITS-1:0] b_data,
  output logic            mac_valid,
  output logic [BITS-1:0] mac_a,
  output logic [BITS-1:0] mac_b,
  input  logic            mac_out_valid,
  input  logic [BITS-1:0] mac_c,
  output logic            c_we,
  output logic [CW-1:0]   c_addr,
  output logic [BITS-1:0] c_data
);

  localparam int IW = clog2_min1(ROWS);
  localparam int JW = clog2_min1(COLS);
  localparam int KW = clog2_min1(INNER);

  localparam logic [IW-1:0] I_LAST = IW'(ROWS - 1);
  localparam logic [JW-1:0] J_LAST = JW'(COLS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(INNER - 1);
  localparam logic [CW:0]   R_LAST = (CW + 1)'(ROWS * COLS - 1);

  state_t state;
  state_t state_next;

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic [CW:0]   r;
  logic          issued_q;

  logic last_issue;
  logic c_write;
  logic r_full;

  assign last_issue = (i == I_LAST) && (j == J_LAST) && (k == K_LAST);
  assign c_write    = mac_out_valid && ((state == ISSUE) || (state == DRAIN));
  assign r_full     = c_write && (r == R_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A full result count wins over the end of issue, so an early finish skips DRAIN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE: begin
        if (r_full) begin
          state_next = FIN;
        end else if (last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN:   if (r_full) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // k is innermost so each run of INNER beats feeds one C element.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i        <= '0;
      j        <= '0;
      k        <= '0;
      r        <= '0;
      issued_q <= 1'b0;
    end else begin
      issued_q <= (state == ISSUE);
      if ((state == IDLE) && start) begin
        i <= '0;
        j <= '0;
        k <= '0;
        r <= '0;
      end else begin
        if (state == ISSUE) begin
          if (k == K_LAST) begin
            k <= '0;
            if (j == J_LAST) begin
              j <= '0;
              i <= (i == I_LAST) ? '0 : i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        if (c_write) begin
          r <= r + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    a_addr    = '0;
    b_addr    = '0;
    if (state == ISSUE) begin
      a_addr = AW'(i) * AW'(INNER) + AW'(k);
      b_addr = BW'(k) * BW'(COLS) + BW'(j);
    end
    mac_valid = issued_q;
    mac_a     = issued_q ? a_data : '0;
    mac_b     = issued_q ? b_data : '0;
    c_we      = c_write;
    c_addr    = c_write ? r[CW-1:0] : '0;
    c_data    = c_write ? mac_c : '0;
  end

endmodule

// File: tb/tb_fixed_matrix_dot_scheduler.sv
// Bench for the matrix product scheduler: 1-cycle memories, a behavioural streaming
// MAC with adjustable latency, and a plain-arithmetic matrix product as reference.
module tb_fixed_matrix_dot_scheduler;
  import fixed_matrix_dot_pkg::*;

  localparam int BITS  = 16;
  localparam int ROWS  = 2;
  localparam int INNER = 3;
  localparam int COLS  = 2;
  localparam int AW    = clog2_min1(ROWS * INNER);
  localparam int BW    = clog2_min1(INNER * COLS);
  localparam int CW    = clog2_min1(ROWS * COLS);
  localparam int NC    = ROWS * COLS;
  localparam int NBEAT = ROWS * COLS * INNER;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic            busy, done, mac_valid, c_we;
  logic [AW-1:0]   a_addr;
  logic [BW-1:0]   b_addr;
  logic [BITS-1:0] a_data, b_data, mac_a, mac_b, mac_c, c_data;
  logic            mac_out_valid;
  logic [CW-1:0]   c_addr;

  logic [BITS-1:0] a_mem [8];
  logic [BITS-1:0] b_mem [8];
  logic [BITS-1:0] exp_c [NC];

  int mac_lat;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  fixed_matrix_dot_scheduler #(
    .BITS(BITS), .ROWS(ROWS), .INNER(INNER), .COLS(COLS)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_data(b_data),
    .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
    .mac_out_valid(mac_out_valid), .mac_c(mac_c),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    a_data <= a_mem[a_addr];
    b_data <= b_mem[b_addr];
  end

  // Streaming MAC: every INNER beats yields one sum, released mac_lat cycles later.
  typedef struct {
    logic [BITS-1:0] val;
    int              due;
  } pending_t;

  pending_t        pend[$];
  logic [BITS-1:0] acc;
  logic [BITS-1:0] mac_sum;
  int              beats;

  always_comb begin
    mac_sum = '0;
    mac_sum = acc + mac_a * mac_b;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend.delete();
      acc           <= '0;
      beats         <= 0;
      mac_out_valid <= 1'b0;
      mac_c         <= '0;
    end else begin
      mac_out_valid <= 1'b0;
      mac_c         <= '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mac_out_valid <= 1'b1;
        mac_c         <= pend[0].val;
        void'(pend.pop_front());
      end
      if (mac_valid) begin
        if (beats == INNER - 1) begin
          pend.push_back('{mac_sum, cyc + mac_lat});
          acc   <= '0;
          beats <= 0;
        end else begin
          acc   <= mac_sum;
          beats <= beats + 1;
        end
      end
    end
  end

  // Observation log; a beat's address is the one presented the cycle before mac_valid.
  logic [CW-1:0]   wr_addr[$];
  logic [BITS-1:0] wr_data[$];
  logic [AW-1:0]   beat_a[$];
  logic [BW-1:0]   beat_b[$];
  logic [BITS-1:0] beat_ma[$];
  logic [BITS-1:0] beat_mb[$];
  int              beat_cyc[$];
  int              done_cnt = 0;
  int              done_cyc = 0;
  logic [AW-1:0]   prev_a;
  logic [BW-1:0]   prev_b;

  always @(negedge clk) begin
    if (c_we) begin
      wr_addr.push_back(c_addr);
      wr_data.push_back(c_data);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (mac_valid) begin
      beat_a.push_back(prev_a);
      beat_b.push_back(prev_b);
      beat_ma.push_back(mac_a);
      beat_mb.push_back(mac_b);
      beat_cyc.push_back(cyc);
    end
    prev_a <= a_addr;
    prev_b <= b_addr;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit use_fixed);
    logic [BITS-1:0] sum;
    for (int n = 0; n < 8; n++) begin
      a_mem[n] = use_fixed ? '0 : BITS'($urandom);
      b_mem[n] = use_fixed ? '0 : BITS'($urandom);
    end
    if (use_fixed) begin
      a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3;
      a_mem[3] = 4; a_mem[4] = 5; a_mem[5] = 6;
      b_mem[0] = 1; b_mem[1] = 0;
      b_mem[2] = 0; b_mem[3] = 1;
      b_mem[4] = 1; b_mem[5] = 1;
    end
    for (int ii = 0; ii < ROWS; ii++) begin
      for (int jj = 0; jj < COLS; jj++) begin
        sum = '0;
        for (int kk = 0; kk < INNER; kk++) begin
          sum = sum + a_mem[ii*INNER + kk] * b_mem[kk*COLS + jj];
        end
        exp_c[ii*COLS + jj] = sum;
      end
    end
  endtask

  // Start one product, optionally re-pulse start mid-run, and check the full trace.
  task automatic runOp(input int mid_start, output int done_delay);
    int wb, db, bb, start_cyc, waited, idle_busy, nw, nb, idx;
    @(negedge clk); #1;
    checkOutput("idle_busy", busy, 0);
    wb = wr_addr.size();
    db = done_cnt;
    bb = beat_a.size();
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    idle_busy = 0;
    while (done_cnt == db && waited < 300) begin
      @(negedge clk); #1;
      waited++;
      if (!busy) idle_busy++;
      if (waited == mid_start) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    checkOutput("done_seen", waited < 300, 1);
    checkOutput("busy_gap", idle_busy, 0);
    done_delay = done_cyc - start_cyc;

    nw = wr_addr.size() - wb;
    checkOutput("write_count", nw, NC);
    for (int n = 0; n < nw && n < NC; n++) begin
      checkOutput("c_addr", wr_addr[wb + n], n);
      checkOutput("c_data", wr_data[wb + n], exp_c[n]);
    end

    nb = beat_a.size() - bb;
    checkOutput("beat_count", nb, NBEAT);
    if (nb == NBEAT) begin
      checkOutput("beat_contiguous", beat_cyc[bb + NBEAT - 1] - beat_cyc[bb], NBEAT - 1);
    end
    idx = 0;
    for (int ii = 0; ii < ROWS; ii++) begin
      for (int jj = 0; jj < COLS; jj++) begin
        for (int kk = 0; kk < INNER; kk++) begin
          if (idx < nb) begin
            checkOutput("a_addr", beat_a[bb + idx], ii*INNER + kk);
            checkOutput("b_addr", beat_b[bb + idx], kk*COLS + jj);
            checkOutput("mac_a", beat_ma[bb + idx], a_mem[ii*INNER + kk]);
            checkOutput("mac_b", beat_mb[bb + idx], b_mem[kk*COLS + jj]);
          end
          idx++;
        end
      end
    end
  endtask

  initial begin
    int d2, d7, d, wb, db, bb, waited;
    rstn = 1'b0;
    start = 1'b0;
    mac_lat = 2;
    applyStimulus(1'b1);
    #2;
    checkOutput("reset_outputs",
                {busy, done, mac_valid, c_we, a_addr, b_addr, mac_a, mac_b, c_addr, c_data}, 0);
    waitCycles(3);
    rstn = 1'b1;
    waitCycles(2);

    $display("[TB] fixed product, MAC latency 2");
    applyStimulus(1'b1);
    checkOutput("ref_c", {exp_c[0], exp_c[1], exp_c[2], exp_c[3]}, {16'd4, 16'd5, 16'd10, 16'd11});
    db = done_cnt;
    runOp(-1, d2);
    waitCycles(10);
    checkOutput("done_pulses", done_cnt - db, 1);
    checkOutput("busy_after_done", busy, 0);

    $display("[TB] start re-pulsed mid-issue");
    applyStimulus(1'b0);
    wb = wr_addr.size();
    db = done_cnt;
    runOp(5, d);
    waitCycles(20);
    checkOutput("midstart_writes", wr_addr.size() - wb, NC);
    checkOutput("midstart_done", done_cnt - db, 1);

    $display("[TB] fixed product, MAC latency 7");
    mac_lat = 7;
    applyStimulus(1'b1);
    runOp(-1, d7);
    checkOutput("latency_shift", d7 - d2, 5);
    waitCycles(5);

    $display("[TB] reset during drain");
    applyStimulus(1'b0);
    bb = beat_a.size();
    @(negedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (beat_a.size() - bb < NBEAT && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    checkOutput("drain_reached", waited < 200, 1);
    waitCycles(2);
    checkOutput("drain_busy", busy, 1);
    rstn = 1'b0;
    #1;
    checkOutput("abort_outputs",
                {busy, done, mac_valid, c_we, a_addr, b_addr, mac_a, mac_b, c_addr, c_data}, 0);
    waitCycles(2);
    rstn = 1'b1;
    wb = wr_addr.size();
    db = done_cnt;
    bb = beat_a.size();
    waitCycles(20);
    checkOutput("abort_no_write", wr_addr.size() - wb, 0);
    checkOutput("abort_no_done", done_cnt - db, 0);
    checkOutput("abort_no_beat", beat_a.size() - bb, 0);
    runOp(-1, d);

    $display("[TB] back-to-back products");
    mac_lat = 2;
    applyStimulus(1'b0);
    wb = wr_addr.size();
    runOp(-1, d);
    applyStimulus(1'b0);
    runOp(-1, d);
    checkOutput("b2b_writes", wr_addr.size() - wb, 2 * NC);

    $display("[TB] random latencies");
    for (int t = 0; t < 3; t++) begin
      mac_lat = int'($urandom_range(1, 9));
      applyStimulus(1'b0);
      runOp(-1, d);
    end

    waitCycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
